// File: rtl/id_ex_operand_stage_pkg.sv
// ============================================================================
//  Module   : id_ex_operand_stage_pkg
//  Brief    : Shared forward-select encodings and defaults for the ID/EX stage
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_ex_operand_stage_pkg;

   localparam logic [1:0] FWD_REG  = 2'b00;
   localparam logic [1:0] FWD_EXE  = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam logic [1:0] FWD_LOAD = 2'b11;

   localparam int         CTRL_W   = 16;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage : id_ex_operand_stage_pkg

`default_nettype wire

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// ============================================================================
//  Module   : operand_fwd_mux
//  Brief    : 4:1 operand forwarding select (regfile / EXE ALU / MEM ALU / load)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fwd_mux
   import id_ex_operand_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] reg_data,
   input  logic [XLEN-1:0] alu_exe,
   input  logic [XLEN-1:0] alu_mem,
   input  logic [XLEN-1:0] load_mem,
   output logic [XLEN-1:0] operand
);

   always_comb begin
      operand = reg_data;
      case (sel)
         FWD_REG:  operand = reg_data;
         FWD_EXE:  operand = alu_exe;
         FWD_MEM:  operand = alu_mem;
         FWD_LOAD: operand = load_mem;
         default:  operand = reg_data;
      endcase
   end

endmodule : operand_fwd_mux

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
//  Module   : id_ex_operand_stage
//  Brief    : ID/EX pipeline register with operand forwarding, hold/flush and
//             saturating bubble/hold performance counters
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter int          CTRL_W   = id_ex_operand_stage_pkg::CTRL_W,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] NOP_INST = id_ex_operand_stage_pkg::NOP_INST
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_DE_EN,
   input  logic              reg_DE_flush,
   input  logic [1:0]        forward_ctrl_A,
   input  logic [1:0]        forward_ctrl_B,
   input  logic              forward_ctrl_ls,
   input  logic              valid_ID,
   input  logic [XLEN-1:0]   PC_ID,
   input  logic [XLEN-1:0]   inst_ID,
   input  logic [XLEN-1:0]   rs1_data_ID,
   input  logic [XLEN-1:0]   rs2_data_ID,
   input  logic [XLEN-1:0]   imm_ID,
   input  logic [4:0]        rd_ID,
   input  logic [4:0]        rs2_ID,
   input  logic [CTRL_W-1:0] ctrl_ID,
   input  logic [XLEN-1:0]   ALUout_EXE,
   input  logic [XLEN-1:0]   ALUout_MEM,
   input  logic [XLEN-1:0]   Datain_MEM,
   output logic              valid_EXE,
   output logic [XLEN-1:0]   PC_EXE,
   output logic [XLEN-1:0]   inst_EXE,
   output logic [XLEN-1:0]   A_EXE,
   output logic [XLEN-1:0]   B_EXE,
   output logic [XLEN-1:0]   imm_EXE,
   output logic [4:0]        rd_EXE,
   output logic [4:0]        rs2_EXE,
   output logic [CTRL_W-1:0] ctrl_EXE,
   output logic [XLEN-1:0]   Dataout_EXE,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  hold_cnt
);

   localparam logic [XLEN-1:0]  NOP_WORD = XLEN'(NOP_INST);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [XLEN-1:0] w_a_fwd;
   logic [XLEN-1:0] w_b_fwd;
   logic            w_hold;
   logic            r_ls_exe;

   operand_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
      .sel      (forward_ctrl_A),
      .reg_data (rs1_data_ID),
      .alu_exe  (ALUout_EXE),
      .alu_mem  (ALUout_MEM),
      .load_mem (Datain_MEM),
      .operand  (w_a_fwd)
   );

   operand_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
      .sel      (forward_ctrl_B),
      .reg_data (rs2_data_ID),
      .alu_exe  (ALUout_EXE),
      .alu_mem  (ALUout_MEM),
      .load_mem (Datain_MEM),
      .operand  (w_b_fwd)
   );

   assign w_hold = !reg_DE_flush && !reg_DE_EN;

   // Flush has priority over hold; a bubble zeroes rd so the hazard unit sees no match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_EXE <= 1'b0;
         PC_EXE    <= '0;
         inst_EXE  <= NOP_WORD;
         A_EXE     <= '0;
         B_EXE     <= '0;
         imm_EXE   <= '0;
         rd_EXE    <= '0;
         rs2_EXE   <= '0;
         ctrl_EXE  <= '0;
         r_ls_exe  <= 1'b0;
      end else if (reg_DE_flush) begin
         valid_EXE <= 1'b0;
         PC_EXE    <= '0;
         inst_EXE  <= NOP_WORD;
         A_EXE     <= '0;
         B_EXE     <= '0;
         imm_EXE   <= '0;
         rd_EXE    <= '0;
         rs2_EXE   <= '0;
         ctrl_EXE  <= '0;
         r_ls_exe  <= 1'b0;
      end else if (reg_DE_EN) begin
         valid_EXE <= valid_ID;
         PC_EXE    <= PC_ID;
         inst_EXE  <= inst_ID;
         A_EXE     <= w_a_fwd;
         B_EXE     <= w_b_fwd;
         imm_EXE   <= imm_ID;
         rd_EXE    <= valid_ID ? rd_ID : 5'd0;
         rs2_EXE   <= rs2_ID;
         ctrl_EXE  <= valid_ID ? ctrl_ID : '0;
         r_ls_exe  <= forward_ctrl_ls;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
         hold_cnt   <= '0;
      end else begin
         if (reg_DE_flush && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + CNT_ONE;
         if (w_hold && (hold_cnt != '1))
            hold_cnt <= hold_cnt + CNT_ONE;
      end
   end

   // Late store-data forward from the load returning in MEM this cycle.
   assign Dataout_EXE = r_ls_exe ? Datain_MEM : B_EXE;

endmodule : id_ex_operand_stage

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
//  Module   : tb_id_ex_operand_stage
//  Brief    : Directed self-checking bench for id_ex_operand_stage
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              reg_DE_EN;
   logic              reg_DE_flush;
   logic [1:0]        forward_ctrl_A;
   logic [1:0]        forward_ctrl_B;
   logic              forward_ctrl_ls;
   logic              valid_ID;
   logic [XLEN-1:0]   PC_ID, inst_ID, rs1_data_ID, rs2_data_ID, imm_ID;
   logic [4:0]        rd_ID, rs2_ID;
   logic [CTRL_W-1:0] ctrl_ID;
   logic [XLEN-1:0]   ALUout_EXE, ALUout_MEM, Datain_MEM;
   logic              valid_EXE;
   logic [XLEN-1:0]   PC_EXE, inst_EXE, A_EXE, B_EXE, imm_EXE, Dataout_EXE;
   logic [4:0]        rd_EXE, rs2_EXE;
   logic [CTRL_W-1:0] ctrl_EXE;
   logic [CNT_W-1:0]  bubble_cnt, hold_cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage #(
      .XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .NOP_INST(32'h0000_0013)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush),
      .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
      .forward_ctrl_ls(forward_ctrl_ls), .valid_ID(valid_ID),
      .PC_ID(PC_ID), .inst_ID(inst_ID), .rs1_data_ID(rs1_data_ID),
      .rs2_data_ID(rs2_data_ID), .imm_ID(imm_ID), .rd_ID(rd_ID), .rs2_ID(rs2_ID),
      .ctrl_ID(ctrl_ID), .ALUout_EXE(ALUout_EXE), .ALUout_MEM(ALUout_MEM),
      .Datain_MEM(Datain_MEM), .valid_EXE(valid_EXE), .PC_EXE(PC_EXE),
      .inst_EXE(inst_EXE), .A_EXE(A_EXE), .B_EXE(B_EXE), .imm_EXE(imm_EXE),
      .rd_EXE(rd_EXE), .rs2_EXE(rs2_EXE), .ctrl_EXE(ctrl_EXE),
      .Dataout_EXE(Dataout_EXE), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [XLEN-1:0] fwd_tbl [4];
      fwd_tbl[0] = 32'h11; fwd_tbl[1] = 32'h22; fwd_tbl[2] = 32'h33; fwd_tbl[3] = 32'h44;

      rst_n = 1'b0; reg_DE_EN = 1'b1; reg_DE_flush = 1'b0;
      forward_ctrl_A = 2'b00; forward_ctrl_B = 2'b00; forward_ctrl_ls = 1'b0;
      valid_ID = 1'b0; PC_ID = '0; inst_ID = '0; rs1_data_ID = '0; rs2_data_ID = '0;
      imm_ID = '0; rd_ID = '0; rs2_ID = '0; ctrl_ID = '0;
      ALUout_EXE = '0; ALUout_MEM = '0; Datain_MEM = '0;
      step(); step();

      check("rst_valid", 64'(valid_EXE), 64'd0);
      check("rst_inst", 64'(inst_EXE), 64'h13);
      check("rst_bubble", 64'(bubble_cnt), 64'd0);
      check("rst_hold", 64'(hold_cnt), 64'd0);
      rst_n = 1'b1;

      // Forwarding sweep, A and B on opposite selects
      valid_ID = 1'b1; PC_ID = 32'h100; inst_ID = 32'h0050_0093; imm_ID = 32'h5;
      rd_ID = 5'd7; rs2_ID = 5'd3; ctrl_ID = 16'hABCD;
      rs1_data_ID = 32'h11; rs2_data_ID = 32'h11;
      ALUout_EXE = 32'h22; ALUout_MEM = 32'h33; Datain_MEM = 32'h44;
      for (int s = 0; s < 4; s++) begin
         forward_ctrl_A = 2'(s);
         forward_ctrl_B = 2'(3 - s);
         step();
         check($sformatf("fwd_A_sel%0d", s), 64'(A_EXE), 64'(fwd_tbl[s]));
         check($sformatf("fwd_B_sel%0d", 3 - s), 64'(B_EXE), 64'(fwd_tbl[3 - s]));
      end
      check("load_valid", 64'(valid_EXE), 64'd1);
      check("load_pc", 64'(PC_EXE), 64'h100);
      check("load_inst", 64'(inst_EXE), 64'h0050_0093);
      check("load_rd", 64'(rd_EXE), 64'd7);
      check("load_rs2", 64'(rs2_EXE), 64'd3);
      check("load_ctrl", 64'(ctrl_EXE), 64'hABCD);
      check("load_imm", 64'(imm_EXE), 64'h5);

      // Hold three edges while ID changes; A was 0x44, B 0x11
      reg_DE_EN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         PC_ID = 32'h200 + 32'(i); rd_ID = 5'd9; forward_ctrl_A = 2'b00;
         forward_ctrl_B = 2'b11; rs1_data_ID = 32'hDEAD;
         step();
      end
      check("hold_pc", 64'(PC_EXE), 64'h100);
      check("hold_rd", 64'(rd_EXE), 64'd7);
      check("hold_A", 64'(A_EXE), 64'h44);
      check("hold_B", 64'(B_EXE), 64'h11);
      check("hold_cnt3", 64'(hold_cnt), 64'd3);
      check("hold_bubble0", 64'(bubble_cnt), 64'd0);

      // Flush wins over hold
      reg_DE_flush = 1'b1; rd_ID = 5'd5;
      step();
      check("flush_valid", 64'(valid_EXE), 64'd0);
      check("flush_rd", 64'(rd_EXE), 64'd0);
      check("flush_inst", 64'(inst_EXE), 64'h13);
      check("flush_A", 64'(A_EXE), 64'd0);
      check("flush_bubble", 64'(bubble_cnt), 64'd1);
      check("flush_hold", 64'(hold_cnt), 64'd3);

      // Store-data forward
      reg_DE_flush = 1'b0; reg_DE_EN = 1'b1;
      forward_ctrl_B = 2'b00; rs2_data_ID = 32'h55; forward_ctrl_ls = 1'b1; Datain_MEM = 32'h99;
      step();
      check("st_fwd_ls1", 64'(Dataout_EXE), 64'h99);
      Datain_MEM = 32'h77;
      #1;
      check("st_fwd_comb", 64'(Dataout_EXE), 64'h77);
      forward_ctrl_ls = 1'b0;
      step();
      check("st_fwd_ls0", 64'(Dataout_EXE), 64'h55);

      // Invalid ID instruction: payload loads, rd/ctrl forced to zero
      valid_ID = 1'b0; rd_ID = 5'd12; ctrl_ID = 16'hFFFF; PC_ID = 32'h300;
      step();
      check("inv_valid", 64'(valid_EXE), 64'd0);
      check("inv_rd", 64'(rd_EXE), 64'd0);
      check("inv_ctrl", 64'(ctrl_EXE), 64'd0);
      check("inv_pc", 64'(PC_EXE), 64'h300);

      // Async reset between edges
      valid_ID = 1'b1; rd_ID = 5'd3; PC_ID = 32'h400; ctrl_ID = 16'h1234;
      step();
      check("pre_rst_rd", 64'(rd_EXE), 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(valid_EXE), 64'd0);
      check("async_rst_inst", 64'(inst_EXE), 64'h13);
      check("async_rst_pc", 64'(PC_EXE), 64'd0);
      check("async_rst_bubble", 64'(bubble_cnt), 64'd0);
      check("async_rst_hold", 64'(hold_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Saturation of bubble counter (4-bit)
      reg_DE_flush = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check("sat_bubble20", 64'(bubble_cnt), 64'hF);
      step();
      check("sat_bubble21", 64'(bubble_cnt), 64'hF);
      check("sat_hold0", 64'(hold_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_id_ex_operand_stage

`default_nettype wire
